// File: rtl/bidir_bus_pkg.sv
// Shared types for the half-duplex bus controller.
// The state encoding and the turnaround counter width helper live here.
package bidir_bus_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TURN_ON  = 2'd1,
    DRIVE    = 2'd2,
    TURN_OFF = 2'd3
  } state_e;

  // Counter wide enough for TA-1, and never zero bits wide.
  function automatic int ta_cnt_w(input int ta);
    int w;
    w = $clog2(ta + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/bidir_pad_cell.sv
// Tristate driver and readback for the shared net.
// This is the only place a high-impedance value is produced.
module bidir_pad_cell #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             oe_i,
  output logic [WIDTH-1:0] rd_o,
  inout  wire  [WIDTH-1:0] pad_io
);

  assign pad_io = oe_i ? data_i : {WIDTH{1'bz}};
  assign rd_o   = pad_io;

endmodule

// File: rtl/bidir_bus_ctrl.sv
// Half-duplex owner of a shared inout net with hi-Z turnaround
// gaps, idle-time sampling and sticky contention detection.
module bidir_bus_ctrl
  import bidir_bus_pkg::*;
#(
  parameter int WIDTH     = 1,
  parameter int TA_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             rx_req,
  output logic             rx_valid,
  output logic [WIDTH-1:0] rx_data,
  inout  wire  [WIDTH-1:0] bus,
  output logic             bus_oe,
  output logic             contention,
  input  logic             clr_contention
);

  localparam int CW = ta_cnt_w(TA_CYCLES);
  localparam int TA_M1 = (TA_CYCLES == 0) ? 0 : TA_CYCLES - 1;
  localparam logic [CW-1:0] TA_LOAD = CW'(TA_M1);

  state_e           state_q, state_d;
  logic [CW-1:0]    ta_cnt_q, ta_cnt_d;
  logic [WIDTH-1:0] drive_q, drive_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             cont_q, cont_d;
  logic             oe_q, oe_d;
  logic             settle_q, settle_d;
  logic [WIDTH-1:0] bus_rd;

  bidir_pad_cell #(.WIDTH(WIDTH)) u_pad (
    .data_i (drive_q),
    .oe_i   (oe_q),
    .rd_o   (bus_rd),
    .pad_io (bus)
  );

  assign tx_ready   = rst_n &&
                      (state_q == IDLE || state_q == DRIVE);
  assign rx_valid   = rx_valid_q;
  assign rx_data    = rx_data_q;
  assign bus_oe     = oe_q;
  assign contention = cont_q;

  always_comb begin
    state_d    = state_q;
    ta_cnt_d   = ta_cnt_q;
    drive_d    = drive_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    cont_d     = cont_q;
    unique case (state_q)
      IDLE: begin
        if (tx_valid) begin
          drive_d = tx_data;
          if (TA_CYCLES == 0) begin
            state_d = DRIVE;
          end else begin
            state_d  = TURN_ON;
            ta_cnt_d = TA_LOAD;
          end
        end else if (rx_req) begin
          rx_valid_d = 1'b1;
          rx_data_d  = bus_rd;
        end
      end
      TURN_ON: begin
        if (ta_cnt_q == '0) state_d = DRIVE;
        else ta_cnt_d = ta_cnt_q - CW'(1);
      end
      DRIVE: begin
        if (tx_valid) begin
          drive_d = tx_data;
        end else if (TA_CYCLES == 0) begin
          state_d = IDLE;
        end else begin
          state_d  = TURN_OFF;
          ta_cnt_d = TA_LOAD;
        end
      end
      TURN_OFF: begin
        if (ta_cnt_q == '0) state_d = IDLE;
        else ta_cnt_d = ta_cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase
    if (clr_contention) cont_d = 1'b0;
    // Readback is ignored on the cycle the driver first turns on.
    if (state_q == DRIVE && !settle_q && (bus_rd !== drive_q))
      cont_d = 1'b1;
  end

  assign oe_d     = (state_d == DRIVE);
  assign settle_d = (state_d == DRIVE) && (state_q != DRIVE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ta_cnt_q   <= '0;
      drive_q    <= '0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      cont_q     <= 1'b0;
      oe_q       <= 1'b0;
      settle_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ta_cnt_q   <= ta_cnt_d;
      drive_q    <= drive_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      cont_q     <= cont_d;
      oe_q       <= oe_d;
      settle_q   <= settle_d;
    end
  end

endmodule

// File: doc/bidir_bus_ctrl.md
Name: bidir_bus_ctrl

Overview:
- Synchronous half-duplex controller for a shared inout net, such as the O pin of the multi-driver pad cells on that net.
- Sits directly upstream of the pad: it owns the local driver on the inout, inserts turnaround gaps before driving and after releasing, samples the net when it is not driving, and flags contention when the net disagrees with what it drives.
- Purpose: keeps the local driver from fighting the lowconn/highconn drivers that produce X on the net.

Parameters:
- WIDTH, 1, bit width of the shared net and of the data paths.
- TA_CYCLES, 1, number of hi-Z turnaround cycles before driving and after releasing. 0 is legal.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- tx_valid  input  1  upstream has a beat to drive.
- tx_ready  output  1  beat accepted when tx_valid && tx_ready.
- tx_data  input  WIDTH  beat to drive.
- rx_req  input  1  request to sample the net while idle.
- rx_valid  output  1  rx_data holds a fresh sample this cycle.
- rx_data  output  WIDTH  sampled net value.
- bus  inout  WIDTH  shared net; driven with drive_q when bus_oe=1, otherwise 'z.
- bus_oe  output  1  registered output enable.
- contention  output  1  sticky flag: net differed from the driven value.
- clr_contention  input  1  clears contention.

Behaviour:
- Reset (rst_n=0 at the clk edge) sets:
  - state IDLE, bus_oe=0, bus='z
  - drive_q=0, tx_ready=0, rx_valid=0, rx_data=0, contention=0, ta_cnt=0
- Reset mid-DRIVE: bus goes hi-Z at the same edge. No turnaround is inserted and the in-flight beat is dropped.
- States: IDLE, TURN_ON, DRIVE, TURN_OFF. bus_oe=1 only in DRIVE.
- tx_ready is combinational: 1 in IDLE and in DRIVE, 0 in TURN_ON, TURN_OFF and during reset.
- IDLE:
  - On a tx handshake, drive_q<=tx_data.
  - Then go to TURN_ON with ta_cnt=TA_CYCLES-1, or straight to DRIVE if TA_CYCLES=0.
  - tx has priority over rx_req in the same cycle.
- TURN_ON: bus hi-Z; ta_cnt decrements each cycle; move to DRIVE after exactly TA_CYCLES cycles.
- DRIVE:
  - The bus shows drive_q.
  - On a handshake, drive_q<=tx_data and the FSM stays in DRIVE. Each new beat appears on the bus the cycle after its acceptance.
  - With tx_valid=0, go to TURN_OFF (or IDLE if TA_CYCLES=0). bus_oe drops at that edge.
- TURN_OFF: bus hi-Z for TA_CYCLES cycles, then IDLE. A tx_valid raised during TURN_OFF waits (tx_ready=0).
- Latency from the IDLE handshake to the beat on the bus: TA_CYCLES+1 edges.
- Receive:
  - In IDLE with rx_req=1 and no tx handshake: rx_data<=bus and rx_valid<=1 at the next edge.
  - Otherwise rx_valid<=0.
  - The net is never sampled in TURN_ON, DRIVE or TURN_OFF.
- Contention:
  - Compare the readback bus against drive_q in every DRIVE cycle except the first cycle after bus_oe rises (settling).
  - Any mismatch, including 4-state X/Z in simulation (case-inequality), sets contention at the next edge.
  - Set wins over a simultaneous clr_contention.
  - contention stays set until cleared or reset.
- Width rule: ta_cnt is $clog2(TA_CYCLES+1) bits, minimum 1. The counter never wraps; it saturates at 0.

Decomposition:
- Package bidir_bus_pkg holds:
  - the state enum (IDLE, TURN_ON, DRIVE, TURN_OFF)
  - a function giving the ta_cnt width from TA_CYCLES
- One sub-module, bidir_pad_cell (WIDTH parameter), is natural. It contains the tristate assign of bus from data/oe and the readback of the net. It is the only place 'z appears.

Test Plan:
- TA_CYCLES=1, WIDTH=1, tx_data=1 pulsed one cycle at t0:
  - bus hi-Z at t0+1, bus=1 at t0+2, hi-Z at t0+3 (TURN_OFF), IDLE at t0+4.
  - tx_ready=0 during t0+1 and t0+3.
- Back-to-back beats 1,0,1 held valid in DRIVE: bus shows 1,0,1 on consecutive cycles with no gap and contention=0.
- External driver forces bus=0 while drive_q=1 on the second DRIVE cycle:
  - contention=1 next edge.
  - clr_contention pulsed while the mismatch persists: stays 1.
  - clr_contention after the external driver releases: clears to 0.
- rx_req=1 in IDLE with external bus=1:
  - rx_valid=1, rx_data=1 the next cycle.
  - tx_valid and rx_req together: tx wins and rx_valid stays 0.
- rst_n=0 while in DRIVE: bus_oe=0 and bus hi-Z at that edge, all outputs at reset values. After release, a new tx needs the full TA_CYCLES turnaround.
- TA_CYCLES=0: IDLE handshake drives the bus on the next edge, and release returns to IDLE directly.
